// File: rtl/display_pkg.sv
// Digit codes shared with the seven_segment decoder, plus converter state
// encoding and a compile-time power-of-ten helper.
package display_pkg;

    localparam logic [3:0] DIGIT_BLANK   = 4'hE;
    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } b2d_state_t;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: add 3 when the BCD nibble is 5 or more.
module bcd_add3 (
    input  logic [3:0] nibble_in,
    output logic [3:0] nibble_out
);

    always_comb begin
        nibble_out = (nibble_in >= 4'd5) ? nibble_in + 4'd3 : nibble_in;
    end

endmodule

// File: rtl/bin_to_digits.sv
// Sequential double-dabble binary-to-decimal converter producing packed
// display digit codes with optional leading-zero blanking and overflow flag.
module bin_to_digits
    import display_pkg::*;
#(
    parameter int BIN_W         = 10,
    parameter int NUM_DIGITS    = 3,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    overflow
);

    localparam int NIB   = NUM_DIGITS + 1;
    localparam int BCD_W = 4 * NIB;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;

    b2d_state_t              state, state_next;
    logic [BIN_W-1:0]        bin;
    logic [BCD_W-1:0]        bcd, bcd_adj;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf_latch;
    logic [4*NUM_DIGITS-1:0] fmt;
    logic                    guard_unused;

    // One adjuster per nibble, including the guard nibble.
    for (genvar g = 0; g < NIB; g++) begin : g_adj
        bcd_add3 u_add3 (
            .nibble_in  (bcd[4*g +: 4]),
            .nibble_out (bcd_adj[4*g +: 4])
        );
    end

    assign guard_unused = bcd_adj[BCD_W-1];
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Leading zeros are blanked scanning down from the MSD; digit 0 is never blanked.
    always_comb begin
        logic        seen;
        int unsigned idx;
        fmt  = bcd[4*NUM_DIGITS-1:0];
        seen = 1'b0;
        idx  = 0;
        for (int unsigned k = 0; k + 1 < NUM_DIGITS; k++) begin
            idx = NUM_DIGITS - 1 - k;
            if (!seen && fmt[4*idx +: 4] == 4'd0) begin
                if (BLANK_LEADING != 0) fmt[4*idx +: 4] = DIGIT_BLANK;
            end else begin
                seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            ovf_latch <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            digits    <= {NUM_DIGITS{DIGIT_BLANK}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin       <= value;
                        bcd       <= '0;
                        cnt       <= CNT_W'(BIN_W);
                        ovf_latch <= (64'(value) > MAX_VAL);
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[BCD_W-2:0], bin[BIN_W-1]};
                    bin <= bin << 1;
                    cnt <= cnt - CNT_W'(1);
                end
                FINISH: begin
                    done     <= 1'b1;
                    overflow <= ovf_latch;
                    digits   <= ovf_latch ? {NUM_DIGITS{DIGIT_INVALID}} : fmt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_digits.sv
// Self-checking bench: cycle-level transaction model plus directed and random conversions.
module tb_bin_to_digits;

    localparam int BIN_W = 10;
    localparam int ND    = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  value;
    logic        busy, done, overflow;
    logic [11:0] digits;
    logic        busy_nb, done_nb, overflow_nb;
    logic [11:0] digits_nb;

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_digits #(.BIN_W(BIN_W), .NUM_DIGITS(ND), .BLANK_LEADING(1)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy), .done(done), .digits(digits), .overflow(overflow)
    );

    bin_to_digits #(.BIN_W(BIN_W), .NUM_DIGITS(ND), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy_nb), .done(done_nb), .digits(digits_nb), .overflow(overflow_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected display for a value, from decimal arithmetic.
    function automatic logic [11:0] expect_digits(input int unsigned v, input bit blank);
        logic [11:0] r;
        int unsigned p;
        r = '0;
        if (v > 999) return 12'hFFF;
        p = 1;
        for (int d = 0; d < 3; d++) begin
            if (blank && d > 0 && v < p) r[4*d +: 4] = 4'hE;
            else                         r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    bit          mvalid = 0;
    int          m_left;
    bit          m_done;
    bit          m_ovf;
    int unsigned m_val;
    logic [11:0] m_dig, m_dig_nb;
    bit          prev_done;

    always @(posedge clk) begin
        if (rst) begin
            mvalid = 1;
            m_left = 0;
            m_done = 0;
            m_ovf  = 0;
            m_dig  = 12'hEEE;
            m_dig_nb = 12'hEEE;
        end else if (mvalid) begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done   = 1;
                    m_ovf    = (m_val > 999);
                    m_dig    = expect_digits(m_val, 1);
                    m_dig_nb = expect_digits(m_val, 0);
                end
            end else if (start) begin
                m_left = BIN_W + 1;
                m_val  = value;
            end
        end
        #1;
        if (mvalid) begin
            check("busy",        busy,        (m_left > 0));
            check("done",        done,        m_done);
            check("digits",      digits,      m_dig);
            check("overflow",    overflow,    m_ovf);
            check("busy_nb",     busy_nb,     (m_left > 0));
            check("done_nb",     done_nb,     m_done);
            check("digits_nb",   digits_nb,   m_dig_nb);
            check("overflow_nb", overflow_nb, m_ovf);
            if (done) check("done_consecutive", prev_done, 1'b0);
            prev_done = done;
        end
    end

    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #2;
            n++;
            if (busy) bc++;
        end
    endtask

    task automatic convert(input int unsigned v, input logic [11:0] exp_d,
                           input logic exp_o, input logic [11:0] exp_nb);
        int n, bc;
        @(negedge clk);
        value = 10'(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        check("latency",     12'(n),    12'd11);
        check("busy_cycles", 12'(bc),   12'd11);
        check("lit_digits",  digits,    exp_d);
        check("lit_ovf",     overflow,  exp_o);
        check("lit_digits_nb", digits_nb, exp_nb);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            if (done) cnt++;
        end
    endtask

    initial begin
        int n, bc, nd;
        int unsigned rv;
        rst = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",   busy,     1'b0);
        check("rst_done",   done,     1'b0);
        check("rst_digits", digits,   12'hEEE);
        check("rst_ovf",    overflow, 1'b0);
        rst = 1'b0;

        convert(725,  12'h725, 1'b0, 12'h725);
        convert(7,    12'hEE7, 1'b0, 12'h007);
        convert(0,    12'hEE0, 1'b0, 12'h000);
        convert(100,  12'h100, 1'b0, 12'h100);
        convert(999,  12'h999, 1'b0, 12'h999);
        convert(1000, 12'hFFF, 1'b1, 12'hFFF);
        convert(1023, 12'hFFF, 1'b1, 12'hFFF);
        convert(5,    12'hEE5, 1'b0, 12'h005);

        // start while busy is ignored
        @(negedge clk);
        value = 10'd512;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        value = 10'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        check("mid_start_done", 12'(n < 40), 12'd1);
        check("mid_start_digits", digits, 12'h512);
        count_dones(20, nd);
        check("mid_start_single_done", 12'(nd), 12'd0);

        // start held high: one conversion per 12 cycles
        @(negedge clk);
        start = 1'b1;
        value = 10'($urandom_range(0, 1023));
        nd = 0;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk);
            #2;
            if (done) nd++;
            value = 10'($urandom_range(0, 1023));
        end
        start = 1'b0;
        check("held_start_dones", 12'(nd), 12'd4);
        repeat (14) @(negedge clk);

        // reset during the 5th SHIFT cycle
        @(negedge clk);
        value = 10'd300;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_busy",   busy,     1'b0);
        check("midrst_digits", digits,   12'hEEE);
        check("midrst_ovf",    overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        count_dones(20, nd);
        check("midrst_no_done", 12'(nd), 12'd0);

        // random conversions, some with ignored mid-conversion starts
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rv = ($urandom_range(0, 3) == 0) ? $urandom_range(995, 1005) : $urandom_range(0, 1023);
            @(negedge clk);
            value = 10'(rv);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 8)) @(negedge clk);
                value = 10'($urandom_range(0, 1023));
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done(n, bc);
            check("rand_done", 12'(n < 40), 12'd1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
